// File: rtl/videomem_pkg.sv
// videomem_pkg: shared FSM states, terminal control codes and sizing helpers
// for the scrolling character terminal.
package videomem_pkg;
    typedef enum logic [1:0] {IDLE, CLR_ROW, CLR_ALL} state_t;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    function automatic int unsigned addr_bits(input int unsigned cells);
        return cells > 1 ? $clog2(cells) : 1;
    endfunction
endpackage

// File: rtl/charmem_dp.sv
// charmem_dp: simple dual-port RAM, one write port and one synchronous read
// port; a same-address read and write in one cycle returns the old data.
module charmem_dp #(
    parameter int DW    = 8,
    parameter int DEPTH = 9600,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i,
    input  logic [AW-1:0] ra_i,
    output logic [DW-1:0] rd_o
);
    logic [DW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wa_i] <= wd_i;
        rd_o <= mem_q[ra_i];
    end
endmodule

// File: rtl/fontrom.sv
// fontrom: combinational 4x8 glyph lookup; bit (row*4 + col) is the pixel.
module fontrom (
    input  logic [7:0]  ch_i,
    output logic [31:0] glyph_o
);
    always_comb
        glyph_o = ch_i == 8'h20 ? 32'h0000_0000 :
                  ch_i == 8'h57 ? 32'h06F9_9999 : {ch_i, ~ch_i, ch_i, ~ch_i};
endmodule

// File: rtl/videomem_term.sv
// videomem_term: character frame buffer acting as a scrolling terminal, with a
// ring-buffer top row and a 2-stage scan-to-RGB display pipeline.
module videomem_term
    import videomem_pkg::*;
#(
    parameter int         DISP_WIDTH_PX  = 640,
    parameter int         DISP_HEIGHT_PX = 480,
    parameter int         CH_WIDTH       = 4,
    parameter int         CH_HEIGHT      = 8,
    parameter int         COLS           = DISP_WIDTH_PX / CH_WIDTH,
    parameter int         ROWS           = DISP_HEIGHT_PX / CH_HEIGHT,
    parameter int         COLOR_BITS     = 6,
    parameter logic [7:0] FILL_CHAR      = 8'd32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                vm_px,
    input  logic [9:0]                vm_py,
    input  logic [7:0]                vm_ch_in,
    input  logic                      vm_ch_write_enable,
    output logic                      vm_ch_ready,
    input  logic                      vm_clear,
    input  logic [3*COLOR_BITS-1:0]   vm_fg_rgb,
    input  logic [3*COLOR_BITS-1:0]   vm_bg_rgb,
    output logic [COLOR_BITS-1:0]     vm_r,
    output logic [COLOR_BITS-1:0]     vm_g,
    output logic [COLOR_BITS-1:0]     vm_b,
    output logic [$clog2(COLS)-1:0]   vm_cur_col,
    output logic [$clog2(ROWS)-1:0]   vm_cur_row,
    output logic [7:0]                debug_curr_ch_out
);
    localparam int CELLS = COLS * ROWS;
    localparam int AW = addr_bits(CELLS);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int GW = $clog2(CH_WIDTH * CH_HEIGHT);
    localparam logic [AW-1:0] LAST = AW'(CELLS - 1);
    localparam logic [AW-1:0] COLS_A = AW'(COLS);

    state_t state_q;
    logic [AW-1:0] addr_q, last_q, mem_wa, rd_addr, row_base;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q, top_q;
    logic ready_q, acc, clr_req, is_bs, is_ctl, la, scroll, mem_we, inr, inr_q;
    logic [7:0] mem_wd, rd_ch, dbg_q;
    logic [GW-1:0] bit_idx, bit_q;
    logic [31:0] glyph;
    logic [3*COLOR_BITS-1:0] rgb, rgb_q;

    // Logical row is rotated by top_q; wrap by compare-and-subtract.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [RW-1:0] top,
                                                input logic [CW-1:0] c);
        logic [RW:0] p;
        p = {1'b0, r} + {1'b0, top};
        if (p >= (RW+1)'(ROWS)) p = p - (RW+1)'(ROWS);
        return AW'(p) * COLS_A + AW'(c);
    endfunction

    always_comb begin
        acc = ready_q && vm_ch_write_enable;
        clr_req = ready_q && (vm_clear || (acc && vm_ch_in == CH_FF));
        is_bs = vm_ch_in == CH_BS;
        is_ctl = vm_ch_in == CH_CR || vm_ch_in == CH_LF || is_bs;
        la = acc && !clr_req && (vm_ch_in == CH_LF || (!is_ctl && col_q == CW'(COLS - 1)));
        scroll = la && row_q == RW'(ROWS - 1);
        row_base = AW'(top_q) * COLS_A;
        mem_we = state_q != IDLE || (acc && !clr_req && (!is_ctl || (is_bs && col_q != '0)));
        mem_wa = state_q != IDLE ? addr_q : cell_addr(row_q, top_q, is_bs ? col_q - 1'b1 : col_q);
        mem_wd = state_q != IDLE || is_bs ? FILL_CHAR : vm_ch_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLR_ALL;
            addr_q <= '0;
            last_q <= LAST;
            col_q <= '0;
            row_q <= '0;
            top_q <= '0;
            ready_q <= 1'b0;
        end else if (state_q != IDLE) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == last_q) begin
                state_q <= IDLE;
                ready_q <= 1'b1;
                if (state_q == CLR_ALL) begin
                    col_q <= '0;
                    row_q <= '0;
                    top_q <= '0;
                end
            end
        end else if (clr_req) begin
            state_q <= CLR_ALL;
            addr_q <= '0;
            last_q <= LAST;
            ready_q <= 1'b0;
        end else if (acc) begin
            if (vm_ch_in == CH_CR || vm_ch_in == CH_LF || (!is_ctl && col_q == CW'(COLS - 1))) col_q <= '0;
            else if (is_bs) col_q <= col_q != '0 ? col_q - 1'b1 : col_q;
            else col_q <= col_q + 1'b1;
            if (la && !scroll) row_q <= row_q + 1'b1;
            // The old top row becomes the new bottom row and must be blanked.
            if (scroll) begin
                top_q <= top_q == RW'(ROWS - 1) ? '0 : top_q + 1'b1;
                state_q <= CLR_ROW;
                addr_q <= row_base;
                last_q <= row_base + COLS_A - 1'b1;
                ready_q <= 1'b0;
            end
        end
    end

    charmem_dp #(.DW(8), .DEPTH(CELLS), .AW(AW)) u_mem (
        .clk(clk), .we_i(mem_we), .wa_i(mem_wa), .wd_i(mem_wd), .ra_i(rd_addr), .rd_o(rd_ch)
    );
    fontrom u_font (.ch_i(rd_ch), .glyph_o(glyph));

    always_comb begin
        inr = vm_px < 10'(DISP_WIDTH_PX) && vm_py < 10'(DISP_HEIGHT_PX);
        rd_addr = inr ? cell_addr(RW'(vm_py / 10'(CH_HEIGHT)), top_q, CW'(vm_px / 10'(CH_WIDTH))) : '0;
        bit_idx = GW'((vm_py % 10'(CH_HEIGHT)) * 10'(CH_WIDTH) + vm_px % 10'(CH_WIDTH));
        rgb = glyph[bit_q] ? vm_fg_rgb : vm_bg_rgb;
    end

    always_ff @(posedge clk) begin
        inr_q <= inr;
        bit_q <= bit_idx;
        if (rst) begin
            rgb_q <= '0;
            dbg_q <= '0;
        end else begin
            rgb_q <= inr_q ? rgb : '0;
            dbg_q <= inr_q ? rd_ch : 8'h00;
        end
    end

    assign {vm_r, vm_g, vm_b} = rgb_q;
    assign debug_curr_ch_out = dbg_q;
    assign vm_ch_ready = ready_q;
    assign vm_cur_col = col_q;
    assign vm_cur_row = row_q;
endmodule

// File: tb/tb_videomem_term.sv
// tb_videomem_term: directed scenario tasks for the scrolling terminal.
module tb_videomem_term;
    logic clk = 1'b0, rst = 1'b1, we = 1'b0, clear = 1'b0, ready;
    logic [9:0] px = '0, py = '0;
    logic [7:0] ch = '0, dbg;
    logic [17:0] fg = '0, bg = '0;
    logic [5:0] r, g, b;
    logic [7:0] cur_col;
    logic [5:0] cur_row;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    videomem_term dut (
        .clk(clk), .rst(rst), .vm_px(px), .vm_py(py), .vm_ch_in(ch),
        .vm_ch_write_enable(we), .vm_ch_ready(ready), .vm_clear(clear),
        .vm_fg_rgb(fg), .vm_bg_rgb(bg), .vm_r(r), .vm_g(g), .vm_b(b),
        .vm_cur_col(cur_col), .vm_cur_row(cur_row), .debug_curr_ch_out(dbg)
    );

    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] v);
        int n;
        wait_ready(n);
        if (n >= 20000) begin
            checks++; errors++;
            $display("FAIL send_timeout: ready stuck low, byte %h", v);
        end
        ch = v; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic read_cell(input int row, input int col, output logic [7:0] v);
        px = 10'(col * 4); py = 10'(row * 8);
        @(negedge clk);
        @(negedge clk);
        v = dbg;
    endtask

    task automatic test_reset;
        int n, bad;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({r, g, b, dbg, ready} !== 33'h0) begin
            errors++; $display("FAIL reset_outputs: rgb=%h dbg=%h ready=%b required 0", {r, g, b}, dbg, ready);
        end
        wait_ready(n);
        checks++;
        if (n !== 9600) begin errors++; $display("FAIL reset_busy_cycles: got %0d required 9600", n); end
        checks++;
        if (cur_col !== 8'd0 || cur_row !== 6'd0) begin
            errors++; $display("FAIL reset_cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
        bad = 0;
        for (int i = 0; i <= 9600; i++) begin
            if (i < 9600) begin px = 10'((i % 160) * 4); py = 10'((i / 160) * 8); end
            @(negedge clk);
            if (i >= 1 && dbg !== 8'h20) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL reset_fill: %0d cells not 0x20, required 0", bad); end
    endtask

    task automatic test_write;
        logic [7:0] v;
        send(8'h48); send(8'h69); send(8'h0D); send(8'h58);
        read_cell(0, 0, v);
        checks++;
        if (v !== 8'h58) begin errors++; $display("FAIL write_cell00: got %h required 58", v); end
        read_cell(0, 1, v);
        checks++;
        if (v !== 8'h69) begin errors++; $display("FAIL write_cell01: got %h required 69", v); end
        checks++;
        if (cur_col !== 8'd1 || cur_row !== 6'd0) begin
            errors++; $display("FAIL write_cursor: got (%0d,%0d) required (0,1)", cur_row, cur_col);
        end
    endtask

    task automatic test_wrap;
        int bad;
        logic [7:0] v;
        send(8'h0D);
        for (int i = 0; i < 160; i++) send(8'h41);
        checks++;
        if (ready !== 1'b1 || cur_col !== 8'd0 || cur_row !== 6'd1) begin
            errors++; $display("FAIL wrap_cursor: got ready=%b (%0d,%0d) required ready=1 (1,0)", ready, cur_row, cur_col);
        end
        bad = 0;
        for (int c = 0; c < 160; c++) begin
            read_cell(0, c, v);
            if (v !== 8'h41) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL wrap_row0: %0d cells not 0x41, required 0", bad); end
        read_cell(1, 0, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL wrap_row1: got %h required 20", v); end
    endtask

    task automatic test_scroll;
        int n, bad;
        logic [7:0] v;
        send(8'h42);
        for (int i = 0; i < 58; i++) send(8'h0A);
        checks++;
        if (cur_row !== 6'd59 || cur_col !== 8'd0) begin
            errors++; $display("FAIL scroll_pre_cursor: got (%0d,%0d) required (59,0)", cur_row, cur_col);
        end
        send(8'h0A);
        wait_ready(n);
        checks++;
        if (n !== 160) begin errors++; $display("FAIL scroll_busy_cycles: got %0d required 160", n); end
        checks++;
        if (cur_row !== 6'd59 || cur_col !== 8'd0) begin
            errors++; $display("FAIL scroll_cursor: got (%0d,%0d) required (59,0)", cur_row, cur_col);
        end
        read_cell(0, 0, v);
        checks++;
        if (v !== 8'h42) begin errors++; $display("FAIL scroll_row0_is_old_row1: got %h required 42", v); end
        bad = 0;
        for (int c = 0; c < 160; c++) begin
            read_cell(59, c, v);
            if (v !== 8'h20) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL scroll_bottom_blank: %0d cells not 0x20, required 0", bad); end
    endtask

    task automatic test_backspace;
        logic [7:0] v;
        send(8'h08);
        checks++;
        if (cur_col !== 8'd0 || cur_row !== 6'd59) begin
            errors++; $display("FAIL bs_col0: got (%0d,%0d) required (59,0)", cur_row, cur_col);
        end
        for (int i = 0; i < 5; i++) send(8'(8'h61 + i));
        send(8'h08);
        checks++;
        if (cur_col !== 8'd4) begin errors++; $display("FAIL bs_col5: got col %0d required 4", cur_col); end
        read_cell(59, 4, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL bs_erase: got %h required 20", v); end
        read_cell(59, 3, v);
        checks++;
        if (v !== 8'h64) begin errors++; $display("FAIL bs_keep: got %h required 64", v); end
    endtask

    task automatic test_formfeed;
        int n;
        logic [7:0] v;
        send(8'h0C);
        wait_ready(n);
        checks++;
        if (n !== 9600) begin errors++; $display("FAIL ff_busy_cycles: got %0d required 9600", n); end
        checks++;
        if (cur_col !== 8'd0 || cur_row !== 6'd0) begin
            errors++; $display("FAIL ff_cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
        read_cell(59, 3, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL ff_cleared: got %h required 20", v); end
    endtask

    task automatic test_clear_with_byte;
        int n, m;
        logic [7:0] v;
        send(8'h4B);
        ch = 8'h5A; we = 1'b1; clear = 1'b1;
        @(negedge clk);
        we = 1'b0; clear = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL clear_entered: ready=%b required 0", ready); end
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready !== 1'b1) n++;
            clear = (i == 50);
            @(negedge clk);
        end
        clear = 1'b0;
        wait_ready(m);
        checks++;
        if (n + m !== 9600) begin errors++; $display("FAIL clear_busy_ignores_clear: got %0d required 9600", n + m); end
        checks++;
        if (cur_col !== 8'd0 || cur_row !== 6'd0) begin
            errors++; $display("FAIL clear_cursor: got (%0d,%0d) required (0,0)", cur_row, cur_col);
        end
        read_cell(0, 0, v);
        checks++;
        if (v !== 8'h20) begin errors++; $display("FAIL clear_cell00: got %h required 20", v); end
    endtask

    task automatic test_glyph;
        send(8'h57);
        fg = 18'h3FFFF; bg = 18'h0;
        px = 10'd1; py = 10'd0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h0) begin errors++; $display("FAIL glyph_r0c1: got %h required 0", {r, g, b}); end
        px = 10'd0;
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h0) begin errors++; $display("FAIL glyph_latency1: got %h required 0", {r, g, b}); end
        @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h3FFFF || dbg !== 8'h57) begin
            errors++; $display("FAIL glyph_r0c0: got rgb=%h dbg=%h required 3ffff 57", {r, g, b}, dbg);
        end
        px = 10'd3;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h3FFFF) begin errors++; $display("FAIL glyph_r0c3: got %h required 3ffff", {r, g, b}); end
        px = 10'd1; py = 10'd6;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h3FFFF) begin errors++; $display("FAIL glyph_r6c1: got %h required 3ffff", {r, g, b}); end
        px = 10'd0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h0) begin errors++; $display("FAIL glyph_r6c0: got %h required 0", {r, g, b}); end
        bg = {6'h15, 6'h2A, 6'h0F};
        px = 10'd1; py = 10'd0;
        @(negedge clk); @(negedge clk);
        checks++;
        if (r !== 6'h15 || g !== 6'h2A || b !== 6'h0F) begin
            errors++; $display("FAIL glyph_bg: got %h %h %h required 15 2a 0f", r, g, b);
        end
        px = 10'd639; py = 10'd479;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== {6'h15, 6'h2A, 6'h0F}) begin errors++; $display("FAIL edge_in_range: got %h required bg", {r, g, b}); end
        px = 10'd640; py = 10'd0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h0) begin errors++; $display("FAIL px640_black: got %h required 0", {r, g, b}); end
        px = 10'd0; py = 10'd480;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({r, g, b} !== 18'h0) begin errors++; $display("FAIL py480_black: got %h required 0", {r, g, b}); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_wrap;
        test_scroll;
        test_backspace;
        test_formfeed;
        test_clear_with_byte;
        test_glyph;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/videomem_term.md
Name: videomem_term

Overview:
- Parametrised successor to the character video memory: a character-cell frame buffer that behaves as a scrolling terminal.
- A writer streams bytes through a valid/ready handshake. The block interprets control codes, advances a hardware cursor, and scrolls with a ring-buffer top-row pointer, so no memory copy is needed.
- The display side converts the scan position (vm_px, vm_py) into registered RGB through a 2-stage pipeline using the existing fontrom.
- Sits between the VGA timing generator and the CPU/UART byte source.

Parameters:
- DISP_WIDTH_PX, 640, active pixels per line
- DISP_HEIGHT_PX, 480, active lines
- CH_WIDTH, 4, glyph width in pixels (CH_WIDTH*CH_HEIGHT must equal the fontrom glyph bit count)
- CH_HEIGHT, 8, glyph height in pixels
- COLS, DISP_WIDTH_PX/CH_WIDTH (160), character columns
- ROWS, DISP_HEIGHT_PX/CH_HEIGHT (60), character rows
- COLOR_BITS, 6, bits per colour channel
- FILL_CHAR, 8'd32, character written by every clear operation

Ports:
- clk  in  1  single clock for the write and display paths
- rst  in  1  synchronous, active-high reset
- vm_px, vm_py  in  10 each  scan position being requested
- vm_ch_in  in  8  byte to write
- vm_ch_write_enable  in  1  byte valid
- vm_ch_ready  out  1  byte accepted when vm_ch_write_enable && vm_ch_ready
- vm_clear  in  1  one-cycle request to clear the screen and home the cursor
- vm_fg_rgb, vm_bg_rgb  in  3*COLOR_BITS each  {r,g,b} colours for glyph bit 1 and glyph bit 0
- vm_r, vm_g, vm_b  out  COLOR_BITS each  pixel colour, registered
- vm_cur_col  out  $clog2(COLS)  cursor column
- vm_cur_row  out  $clog2(ROWS)  cursor row
- debug_curr_ch_out  out  8  character code at the scan position, aligned with the RGB outputs

Behaviour:
- Reset (rst high on a clk edge):
  - cursor set to (0,0); top_row set to 0; vm_r/g/b set to 0; debug_curr_ch_out set to 0; vm_ch_ready set to 0.
  - FSM enters CLR_ALL. rst held high keeps it in CLR_ALL at index 0.
  - Reset mid-operation aborts any clear or scroll and restarts CLR_ALL.
- FSM states:
  - IDLE: vm_ch_ready=1.
  - CLR_ALL: writes FILL_CHAR to address idx, idx counting 0..COLS*ROWS-1, one address per cycle. At the end it sets top_row=0 and cursor=(0,0), then goes to IDLE. Takes COLS*ROWS cycles; ready is low throughout.
  - CLR_ROW: writes FILL_CHAR to COLS consecutive addresses of one physical row, then goes to IDLE. Ready is low.
- Address mapping: physical row = (logical row + top_row) mod ROWS; address = physical row * COLS + col. The wrap is done by compare-and-subtract, not by a modulo operator on a non-power-of-two.
- Byte handling (IDLE, on an accepted byte), with line advance (LA) defined below:
  - 0x0D CR: col=0.
  - 0x0A LF: col=0, then LA.
  - 0x08 BS: if col>0, decrement col and write FILL_CHAR there. At col==0 it is a no-op; there is no wrap to the previous row.
  - 0x0C FF: behaves as vm_clear.
  - Any other byte: write it at the cursor and increment col. If col reaches COLS, set col=0 and do LA.
- Line advance (LA):
  - If row < ROWS-1: increment row.
  - Otherwise: top_row = (top_row+1) mod ROWS, row stays ROWS-1, and the FSM enters CLR_ROW on the physical row that was the old top row, which is now the bottom.
- vm_clear: honoured only in IDLE and ignored while busy. If it coincides with an accepted byte, the clear wins and the byte is consumed and discarded. The FSM enters CLR_ALL.
- Handshake: while ready is low, vm_ch_write_enable is ignored with no side effects. The producer holds the byte until it is accepted. Ready goes low on the cycle after a byte that triggers a scroll or clear.
- Display pipeline:
  - Stage 1 registers the memory read of the character at the mapped address.
  - Stage 2 registers glyph bit [(py%CH_HEIGHT)*CH_WIDTH + px%CH_WIDTH], selecting fg or bg.
  - Latency is exactly 2 cycles from vm_px/vm_py to vm_r/g/b and debug_curr_ch_out.
  - A position with px ≥ DISP_WIDTH_PX or py ≥ DISP_HEIGHT_PX outputs 0, not bg.
- Read/write collision: a read and a write to the same address in the same cycle return the old data. The memory is a simple dual-port block RAM.

Decomposition:
- Package videomem_pkg holds:
  - FSM state enum (IDLE, CLR_ROW, CLR_ALL);
  - control-code constants CH_CR, CH_LF, CH_BS, CH_FF;
  - localparam helpers for address widths.
- The one natural sub-module is charmem_dp: a parametrised simple dual-port RAM with synchronous read, one write port and one read port. fontrom is reused unchanged.

Test Plan:
- Reset with defaults, rst held 1 cycle -> vm_ch_ready low for exactly 9600 cycles, then high. Every cell reads 0x20 and the cursor is (0,0).
- Write "Hi" then CR, then "X" -> cell (0,0)=0x58 and (0,1)=0x69; cursor=(0,1).
- Write 160 'A' bytes -> cursor wraps to (1,0), row 0 is all 0x41, and no scroll occurs.
- Cursor at row 59, send LF -> top_row=1, ready low for 160 cycles, and physical row 0 is filled with 0x20. Scan line py=472 (logical row 59) shows blank, and logical row 0 shows the old row 1.
- BS at col 0 -> no change. BS at col 5 -> col=4 and cell 4 = 0x20. vm_clear asserted together with byte 'Z' -> CLR_ALL entered and 'Z' is never written.
- Scan with fg=all-ones and bg=0 over cell 'W' -> RGB equals the glyph bits 2 cycles later. px=640 -> RGB=0.
